set_mode_sequencer: RTL and testbench

//  Sequences user editing of clock time and alarm time from the debounced button pulses.

---
 rtl/set_mode_sequencer.sv | 123 ++++++++++++
 tb/tb_set_mode_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/set_mode_sequencer.sv
// Clock/alarm edit sequencer: mode stepping, increment strobes with
// hold-to-repeat, inactivity timeout and field blink for the display.
module set_mode_sequencer #(
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int TIMEOUT_SEC   = 10,
  parameter int BLINK_CYCLES  = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_tick,
  input  logic       mode_pulse,
  input  logic       inc_pulse,
  input  logic       inc_level,
  output logic       inc_hour,
  output logic       inc_min,
  output logic       inc_alarm_hour,
  output logic       inc_alarm_min,
  output logic       disp_alarm,
  output logic       blank_hour,
  output logic       blank_min,
  output logic [2:0] state
);
  localparam logic [2:0] RUN    = 3'd0;
  localparam logic [2:0] SET_H  = 3'd1;
  localparam logic [2:0] SET_M  = 3'd2;
  localparam logic [2:0] SET_AH = 3'd3;
  localparam logic [2:0] SET_AM = 3'd4;

  localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HW = $clog2(HMAX + 1) + 1;
  localparam int IW = $clog2(TIMEOUT_SEC + 1) + 1;
  localparam int BW = $clog2(BLINK_CYCLES + 1) + 1;

  // The press cycle itself counts toward the hold time, hence the -2.
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 2);
  localparam logic [HW-1:0] REP_LAST   = HW'(REPEAT_CYCLES - 1);
  localparam logic [IW-1:0] IDLE_MAX   = IW'(TIMEOUT_SEC);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  logic [HW-1:0] hold;
  logic          rep;
  logic [IW-1:0] idle;
  logic [BW-1:0] bcnt;
  logic          phase;

  logic [2:0]    nxt;
  logic          edit;
  logic          expire;
  logic          chg;
  logic          fire;
  logic          strobe;
  logic [BW-1:0] bcnt_n;
  logic          phase_n;

  always_comb begin
    edit   = (state != RUN) && (state <= SET_AM);
    expire = edit && (idle == IDLE_MAX);
    nxt    = state;
    if (state > SET_AM)
      nxt = RUN;
    else if (mode_pulse)
      nxt = (state == SET_AM) ? RUN : state + 3'd1;
    else if (expire)
      nxt = RUN;
    chg    = (nxt != state);
    fire   = edit && inc_level &&
             (rep ? (hold == REP_LAST) : (hold == HOLD_LAST));
    strobe = edit && !chg && (inc_pulse || fire);
    bcnt_n  = bcnt + BW'(1);
    phase_n = phase;
    if (chg) begin
      bcnt_n  = '0;
      phase_n = 1'b0;
    end else if (bcnt == BLINK_LAST) begin
      bcnt_n  = '0;
      phase_n = !phase;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= RUN;
      hold           <= '0;
      rep            <= 1'b0;
      idle           <= '0;
      bcnt           <= '0;
      phase          <= 1'b0;
      inc_hour       <= 1'b0;
      inc_min        <= 1'b0;
      inc_alarm_hour <= 1'b0;
      inc_alarm_min  <= 1'b0;
      disp_alarm     <= 1'b0;
      blank_hour     <= 1'b0;
      blank_min      <= 1'b0;
    end else begin
      state <= nxt;
      if (chg || !edit || inc_pulse || !inc_level) begin
        hold <= '0;
        rep  <= 1'b0;
      end else if (fire) begin
        hold <= '0;
        rep  <= 1'b1;
      end else begin
        hold <= hold + HW'(1);
      end
      if (nxt == RUN || mode_pulse || inc_pulse || strobe)
        idle <= '0;
      else if (sec_tick && idle != IDLE_MAX)
        idle <= idle + IW'(1);
      bcnt           <= bcnt_n;
      phase          <= phase_n;
      inc_hour       <= strobe && (state == SET_H);
      inc_min        <= strobe && (state == SET_M);
      inc_alarm_hour <= strobe && (state == SET_AH);
      inc_alarm_min  <= strobe && (state == SET_AM);
      disp_alarm     <= (nxt == SET_AH) || (nxt == SET_AM);
      blank_hour     <= phase_n && ((nxt == SET_H) || (nxt == SET_AH));
      blank_min      <= phase_n && ((nxt == SET_M) || (nxt == SET_AM));
    end
  end

endmodule

// File: tb/tb_set_mode_sequencer.sv
// Bench for set_mode_sequencer: directed scenarios plus random
// stimulus, all checked against a rule-level reference model.
module tb_set_mode_sequencer;
  localparam int H = 8;
  localparam int R = 4;
  localparam int T = 3;
  localparam int B = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sec_tick = 1'b0;
  logic       mode_pulse = 1'b0;
  logic       inc_pulse = 1'b0;
  logic       inc_level = 1'b0;
  logic       inc_hour;
  logic       inc_min;
  logic       inc_alarm_hour;
  logic       inc_alarm_min;
  logic       disp_alarm;
  logic       blank_hour;
  logic       blank_min;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  // model: state, cycles since press/clear, idle ticks, cycles since state change
  int ms  = 0;
  int age = 0;
  int idl = 0;
  int bt  = 0;
  bit str = 0;
  int sms = 0;

  always #5 clk = ~clk;

  set_mode_sequencer #(
    .HOLD_CYCLES(H),
    .REPEAT_CYCLES(R),
    .TIMEOUT_SEC(T),
    .BLINK_CYCLES(B)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sec_tick(sec_tick),
    .mode_pulse(mode_pulse),
    .inc_pulse(inc_pulse),
    .inc_level(inc_level),
    .inc_hour(inc_hour),
    .inc_min(inc_min),
    .inc_alarm_hour(inc_alarm_hour),
    .inc_alarm_min(inc_alarm_min),
    .disp_alarm(disp_alarm),
    .blank_hour(blank_hour),
    .blank_min(blank_min),
    .state(state)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit m, input bit t,
                            input bit ip, input bit il);
    bit edit;
    bit chg;
    int nxt;
    if (!r) begin
      ms = 0; age = 0; idl = 0; bt = 0; str = 0; sms = 0;
      return;
    end
    edit = (ms >= 1) && (ms <= 4);
    if (ms > 4) nxt = 0;
    else if (m) nxt = (ms + 1) % 5;
    else if (edit && idl >= T) nxt = 0;
    else nxt = ms;
    chg = (nxt != ms);
    str = 0;
    sms = ms;
    if (edit && !chg && ip) begin
      age = 0;
      str = 1;
    end else if (edit && !chg && il) begin
      age++;
      if (age == H - 1 || (age > H - 1 && (age - (H - 1)) % R == 0))
        str = 1;
    end else begin
      age = 0;
    end
    if (nxt == 0 || m || ip || str) idl = 0;
    else if (t) idl++;
    bt = chg ? 0 : bt + 1;
    ms = nxt;
  endtask

  task automatic compare();
    int ph;
    int sv;
    int se;
    ph = (bt / B) % 2;
    sv = {inc_alarm_min, inc_alarm_hour, inc_min, inc_hour};
    se = str ? (1 << (sms - 1)) : 0;
    check("state", state, ms);
    check("strobes", sv, se);
    check("disp_alarm", disp_alarm, (ms == 3 || ms == 4));
    check("blank_hour", blank_hour, ph == 1 && (ms == 1 || ms == 3));
    check("blank_min", blank_min, ph == 1 && (ms == 2 || ms == 4));
  endtask

  task automatic cyc(input bit r, input bit m, input bit t,
                     input bit ip, input bit il);
    @(negedge clk);
    rst = r; mode_pulse = m; sec_tick = t; inc_pulse = ip; inc_level = il;
    @(posedge clk);
    model_step(r, m, t, ip, il);
    #1;
    compare();
  endtask

  task automatic do_reset();
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    int hits[$];
    int exp_hits[$];
    int exp_st[5];
    bit lvl;
    bit ph_seen;

    // reset and full mode cycle
    do_reset();
    check("reset_state", state, 0);
    check("reset_disp", disp_alarm, 0);
    exp_st = '{1, 2, 3, 4, 0};
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 0, 0, 0);
      check("mode_seq", state, exp_st[i]);
      check("mode_disp", disp_alarm, (exp_st[i] >= 3));
    end

    // single press in SET_M
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0);
    check("setm_strobe", inc_min, 1);
    cyc(1, 0, 0, 0, 0);
    check("setm_strobe_end", inc_min, 0);
    for (int i = 0; i < 12; i++) cyc(1, 0, 0, 0, 0);

    // hold-to-repeat in SET_H
    do_reset();
    cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 1);
    if (inc_hour) hits.push_back(1);
    for (int k = 1; k < 30; k++) begin
      cyc(1, 0, 0, 0, k <= 18);
      if (inc_hour) hits.push_back(k + 1);
    end
    exp_hits = '{1, 8, 12, 16};
    check("repeat_count", hits.size(), 4);
    for (int i = 0; i < 4; i++)
      check("repeat_time", (i < hits.size()) ? hits[i] : -1, exp_hits[i]);

    // timeout in SET_AH with a restarting press
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    check("no_timeout_yet", state, 3);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("timeout_run", state, 0);

    // mode beats inc, inc ignored in RUN
    do_reset();
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 1, 0);
    check("mode_over_inc", state, 2);
    cyc(1, 0, 0, 0, 0);
    check("mode_over_inc_nostb", inc_hour | inc_min, 0);
    do_reset();
    cyc(1, 0, 0, 1, 1);
    cyc(1, 0, 0, 0, 0);

    // reset mid-repeat in SET_AM
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 1);
    for (int i = 0; i < 14; i++) cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    check("rst_state", state, 0);
    check("rst_outs", {inc_hour, inc_min, inc_alarm_hour, inc_alarm_min,
                       disp_alarm, blank_hour, blank_min}, 0);
    for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0);

    // random
    lvl = 0;
    ph_seen = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 24) == 0) lvl = !lvl;
      cyc($urandom_range(0, 299) != 0,
          $urandom_range(0, 39) == 0,
          $urandom_range(0, 7) == 0,
          $urandom_range(0, 29) == 0,
          lvl);
      if (blank_hour || blank_min) ph_seen = 1;
    end
    check("blink_seen", ph_seen, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
